// File: rtl/cprv_lsu.sv
// ---------------------------------------------------------------------------
// cprv_lsu : load/store unit for the RV64I core
//
// Takes one LOAD/STORE at a time from the ALU's effective-address stage. It
// drives a 64-bit, doubleword-aligned memory port with byte strobes and
// returns sign- or zero-extended load data to writeback.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   lsu_valid/ready request handshake; ready is high only while idle
//   opcode, funct3  LOAD/STORE opcode and size/sign field
//   addr            effective address
//   store_data      rs2 value, low bytes used
//   lsu_done        one-cycle completion pulse
//   load_data       extended load result, non-zero only with lsu_done on loads
//   lsu_illegal     with lsu_done: bad opcode/funct3, no bus access made
//   lsu_misalign    with lsu_done: misaligned access (trap build only)
//   mem_*           doubleword bus; mem_valid is held until mem_ready
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned H/W/D accesses skip the bus and
//                     report lsu_misalign. When undefined, the low offset bits
//                     are cleared to natural alignment and the access proceeds.
// ---------------------------------------------------------------------------
module cprv_lsu #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      lsu_done,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic                      lsu_illegal,
  output logic                      lsu_misalign,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                    accept;
  logic                    req_illegal;
  logic                    req_misalign;
  logic                    req_skip;
  logic [2:0]              align_mask;
  logic [2:0]              req_off;
  logic [DATA_WIDTH/8-1:0] size_mask;

  logic                    is_load_q;
  logic                    we_q;
  logic                    illegal_q;
  logic [2:0]              funct3_q;
  logic [2:0]              off_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [DATA_WIDTH-1:0]   rdata_shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign accept = lsu_valid && (state_q == IDLE);

  // Request decode: legality, access size, and the byte offset on the bus.
  // The offset is always rounded down to natural alignment; in the trap build
  // a misaligned access never reaches the bus, so this only matters otherwise.
  always_comb begin
    req_illegal = 1'b1;
    align_mask  = 3'b111;
    size_mask   = 8'hFF;
    if (opcode == OP_LOAD) begin
      req_illegal = (funct3 == 3'b111);
    end else if (opcode == OP_STORE) begin
      req_illegal = funct3[2];
    end
    case (funct3[1:0])
      2'b00:   begin align_mask = 3'b000; size_mask = 8'h01; end
      2'b01:   begin align_mask = 3'b001; size_mask = 8'h03; end
      2'b10:   begin align_mask = 3'b011; size_mask = 8'h0F; end
      default: begin align_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    req_off = addr[2:0] & ~align_mask;
  end

`ifdef MISALIGN_TRAP_EN
  // Illegal wins over misaligned, so misalign is only flagged on legal requests.
  assign req_misalign = !req_illegal && ((addr[2:0] & align_mask) != 3'b000);
`else
  assign req_misalign = 1'b0;
`endif

  assign req_skip = req_illegal || req_misalign;

  // Load extraction: shift the addressed lane down, then extend per funct3.
  always_comb begin
    rdata_shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
      3'b001:  load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'b011:  load_ext = rdata_shifted;
      3'b100:  load_ext = {56'd0, rdata_shifted[7:0]};
      3'b101:  load_ext = {48'd0, rdata_shifted[15:0]};
      3'b110:  load_ext = {32'd0, rdata_shifted[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Next-state logic. Illegal or misaligned requests go straight to RESP
  // so the bus is never touched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lsu_valid) state_d = req_skip ? RESP : REQ;
      REQ:     if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers. Bus fields are frozen at accept so they stay
  // stable however long mem_ready is held low. Reset drops any in-flight
  // request, and a late mem_ready then lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_load_q <= (opcode == OP_LOAD);
        we_q      <= (opcode == OP_STORE);
        illegal_q <= req_illegal;
        funct3_q  <= funct3;
        off_q     <= req_off;
        addr_q    <= {addr[ADDR_WIDTH-1:3], 3'b000};
        wstrb_q   <= (opcode == OP_STORE) ? (size_mask << req_off) : '0;
        wdata_q   <= (opcode == OP_STORE) ? (store_data << {req_off, 3'b000}) : '0;
        result_q  <= '0;
      end else if ((state_q == REQ) && mem_ready) begin
        result_q <= is_load_q ? load_ext : '0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= req_misalign;
    end
  end

  assign lsu_misalign = (state_q == RESP) && misalign_q;
`else
  assign lsu_misalign = 1'b0;
`endif

  // Outputs are gated by state so everything but lsu_ready idles at zero.
  assign lsu_ready   = (state_q == IDLE);
  assign lsu_done    = (state_q == RESP);
  assign lsu_illegal = (state_q == RESP) && illegal_q;
  assign load_data   = (state_q == RESP) ? result_q : '0;
  assign mem_valid   = (state_q == REQ);
  assign mem_we      = (state_q == REQ) && we_q;
  assign mem_addr    = (state_q == REQ) ? addr_q  : '0;
  assign mem_wstrb   = (state_q == REQ) ? wstrb_q : '0;
  assign mem_wdata   = (state_q == REQ) ? wdata_q : '0;

endmodule
